// File: rtl/lut_neuron_scheduler_if.sv
// Handshake and configuration bundle for lut_neuron_scheduler.
// The master drives vectors, config writes and out_ready; the slave is the scheduler.
interface lut_neuron_scheduler_if #(
    parameter int IN_WIDTH    = 16,
    parameter int FAN_IN      = 8,
    parameter int NUM_NEURONS = 8,
    parameter int IDX_W       = 4,
    parameter int NID_W       = 3
);
    localparam int SLOT_W = $clog2(FAN_IN);

    logic                   in_valid;
    logic                   in_ready;
    logic [IN_WIDTH-1:0]    in_vec;
    logic                   out_valid;
    logic                   out_ready;
    logic [NUM_NEURONS-1:0] out_vec;
    logic                   busy;

    logic                   tbl_we;
    logic [NID_W-1:0]       tbl_neuron;
    logic [FAN_IN-1:0]      tbl_addr;
    logic                   tbl_bit;

    logic                   conn_we;
    logic [NID_W-1:0]       conn_neuron;
    logic [SLOT_W-1:0]      conn_slot;
    logic [IDX_W-1:0]       conn_idx;

    modport master (
        output in_valid, in_vec, out_ready,
        output tbl_we, tbl_neuron, tbl_addr, tbl_bit,
        output conn_we, conn_neuron, conn_slot, conn_idx,
        input  in_ready, out_valid, out_vec, busy
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        input  tbl_we, tbl_neuron, tbl_addr, tbl_bit,
        input  conn_we, conn_neuron, conn_slot, conn_idx,
        output in_ready, out_valid, out_vec, busy
    );
endinterface

// File: rtl/lut_neuron_scheduler.sv
// Time-multiplexed LUT neuron layer: one shared truth-table store and input
// crossbar evaluate NUM_NEURONS neurons, one per cycle, over a captured vector.
module lut_neuron_scheduler #(
    parameter int IN_WIDTH    = 16,
    parameter int FAN_IN      = 8,
    parameter int NUM_NEURONS = 8,
    parameter int IDX_W       = 4,
    parameter int NID_W       = 3
) (
    input logic                   clk,
    input logic                   rst,
    lut_neuron_scheduler_if.slave bus
);
    localparam int DEPTH = 2 ** FAN_IN;
    localparam int EXT_W = 2 ** IDX_W;
    localparam logic [NID_W-1:0] LAST = NID_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [NID_W-1:0]       cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]    vec_q, vec_d;
    logic [NUM_NEURONS-1:0] out_vec_q, out_vec_d;

    logic [DEPTH-1:0]       tbl_q  [NUM_NEURONS];
    logic [IDX_W-1:0]       conn_q [NUM_NEURONS][FAN_IN];

    logic [EXT_W-1:0]       vec_ext;
    logic [FAN_IN-1:0]      addr;
    logic                   cfg_en;
    logic                   tbl_hit;
    logic                   conn_hit;
    logic                   in_ready;
    logic                   out_valid;
    logic                   busy;

    // Zero-padding the vector to the full index range makes any index at or
    // beyond IN_WIDTH read as 0 without a separate range comparison.
    always_comb begin
        vec_ext = EXT_W'(vec_q);
        addr    = '0;
        for (int k = 0; k < FAN_IN; k++) begin
            addr[k] = vec_ext[conn_q[cnt_q][k]];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vec_d     = vec_q;
        out_vec_d = out_vec_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    vec_d   = bus.in_vec;
                    cnt_d   = '0;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                busy             = 1'b1;
                out_vec_d[cnt_q] = tbl_q[cnt_q][addr];
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            out_vec_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_vec_q <= out_vec_d;
        end
    end

    always_ff @(posedge clk) begin
        vec_q <= vec_d;
    end

    // Config writes land only while idle; writes in other states are dropped.
    assign cfg_en   = (state_q == S_IDLE);
    assign tbl_hit  = cfg_en && bus.tbl_we  && (32'(bus.tbl_neuron)  < NUM_NEURONS);
    assign conn_hit = cfg_en && bus.conn_we && (32'(bus.conn_neuron) < NUM_NEURONS);

    always_ff @(posedge clk) begin
        if (tbl_hit) begin
            tbl_q[bus.tbl_neuron][bus.tbl_addr] <= bus.tbl_bit;
        end
        if (conn_hit) begin
            conn_q[bus.conn_neuron][bus.conn_slot] <= bus.conn_idx;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.out_vec   = out_vec_q;
endmodule

// File: tb/tb_lut_neuron_scheduler.sv
// Scoreboard bench for lut_neuron_scheduler: a behavioural layer model predicts
// each result at accept time; a monitor checks results, latency and DONE behaviour.
module tb_lut_neuron_scheduler;
    localparam int IN_W   = 12;
    localparam int FAN_IN = 8;
    localparam int NN     = 8;
    localparam int IDX_W  = 4;
    localparam int NID_W  = 3;
    localparam int DEPTH  = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lut_neuron_scheduler_if #(
        .IN_WIDTH(IN_W), .FAN_IN(FAN_IN), .NUM_NEURONS(NN), .IDX_W(IDX_W), .NID_W(NID_W)
    ) bus ();

    lut_neuron_scheduler #(
        .IN_WIDTH(IN_W), .FAN_IN(FAN_IN), .NUM_NEURONS(NN), .IDX_W(IDX_W), .NID_W(NID_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NN-1:0] e;
        int            acc;
    } item_t;

    item_t sb[$];
    bit    ref_tbl  [NN][DEPTH];
    int    ref_conn [NN][FAN_IN];
    int    cyc     = 0;
    int    n_tests = 0;
    int    n_fail  = 0;
    item_t cur;
    bit    in_done = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: address bit k is input bit conn[n][k], or 0 when that index is past the vector.
    function automatic logic [NN-1:0] model(input logic [IN_W-1:0] v);
        logic [NN-1:0] r;
        int a;
        for (int n = 0; n < NN; n++) begin
            a = 0;
            for (int k = 0; k < FAN_IN; k++) begin
                if (ref_conn[n][k] < IN_W) begin
                    if (v[ref_conn[n][k]]) a += (1 << k);
                end
            end
            r[n] = ref_tbl[n][a];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            in_done = 1'b0;
        end else if (bus.out_valid) begin
            if (!in_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    check("out_vec", bus.out_vec, cur.e);
                    check("latency", cyc, cur.acc + NN);
                end
                in_done = 1'b1;
            end else begin
                check("out_vec_stable", bus.out_vec, cur.e);
            end
            check("in_ready_in_done", bus.in_ready, 32'd0);
            check("busy_in_done", bus.busy, 32'd1);
            if (bus.out_ready) in_done = 1'b0;
        end
    end

    task automatic cfg(input bit te, input int n, input int a, input bit b,
                       input bit ce, input int cn, input int slot, input int idx);
        bus.tbl_we      = te;
        bus.tbl_neuron  = NID_W'(n);
        bus.tbl_addr    = FAN_IN'(a);
        bus.tbl_bit     = b;
        bus.conn_we     = ce;
        bus.conn_neuron = NID_W'(cn);
        bus.conn_slot   = 3'(slot);
        bus.conn_idx    = IDX_W'(idx);
        if (te) ref_tbl[n][a] = b;
        if (ce) ref_conn[cn][slot] = idx;
        @(posedge clk); #1;
        bus.tbl_we  = 1'b0;
        bus.conn_we = 1'b0;
    endtask

    // mode 0: only address FF is 1; mode 1: table[n][a] = a[n]; mode 2: random table and wiring.
    task automatic prog(input int mode);
        bit b;
        int idx;
        for (int n = 0; n < NN; n++) begin
            for (int a = 0; a < DEPTH; a++) begin
                case (mode)
                    0:       b = (a == 255);
                    1:       b = a[n];
                    default: b = 1'($urandom);
                endcase
                idx = (mode == 2) ? int'($urandom_range(0, 15)) : a;
                cfg(1'b1, n, a, b, a < FAN_IN, n, a % FAN_IN, idx);
            end
        end
    endtask

    task automatic send(input logic [IN_W-1:0] v);
        int t;
        logic [NN-1:0] e;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("in_ready_before_send", bus.in_ready, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        e = model(v);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sb.push_back('{e: e, acc: cyc});
    endtask

    task automatic finish_vec(input int hold, input bit poke, input int poke_addr);
        int t;
        int pn;
        t = 0;
        while (!bus.out_valid && t < 30) begin
            @(posedge clk); #1;
            t++;
        end
        check("out_valid_seen", bus.out_valid, 32'd1);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                pn = i % NN;
                bus.tbl_we     = 1'b1;
                bus.tbl_neuron = NID_W'(pn);
                bus.tbl_addr   = FAN_IN'(poke_addr);
                bus.tbl_bit    = ~ref_tbl[pn][poke_addr];
            end
            @(posedge clk); #1;
            bus.tbl_we = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("idle_after_ack", bus.in_ready, 32'd1);
        check("out_valid_low_after_ack", bus.out_valid, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_W-1:0] v;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_vec = '0; bus.out_ready = 1'b0;
        bus.tbl_we = 1'b0; bus.tbl_neuron = '0; bus.tbl_addr = '0; bus.tbl_bit = 1'b0;
        bus.conn_we = 1'b0; bus.conn_neuron = '0; bus.conn_slot = '0; bus.conn_idx = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", bus.in_ready, 32'd1);
        check("rst_out_valid", bus.out_valid, 32'd0);
        check("rst_out_vec", bus.out_vec, 32'd0);
        check("rst_busy", bus.busy, 32'd0);

        prog(0);
        send(12'h0FF); finish_vec(0, 1'b0, 0);
        send(12'h0FE); finish_vec(0, 1'b0, 0);

        // Writes during DONE must be dropped; the rerun still sees the old table.
        send(12'h0FF); finish_vec(5, 1'b1, 255);
        send(12'h0FF); finish_vec(0, 1'b0, 0);

        bus.tbl_we = 1'b1; bus.tbl_neuron = '0; bus.tbl_addr = '0; bus.tbl_bit = 1'b1;
        ref_tbl[0][0] = 1'b1;
        send(12'h000);
        bus.tbl_we = 1'b0;
        finish_vec(1, 1'b0, 0);

        prog(1);
        send(12'h0A5); finish_vec(0, 1'b0, 0);

        cfg(1'b0, 0, 0, 1'b0, 1'b1, 3, 0, 15);
        cfg(1'b1, 3, 255, 1'b0, 1'b0, 0, 0, 0);
        send(12'hFFF); finish_vec(0, 1'b0, 0);

        send(12'h0A5);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check("abort_out_valid", bus.out_valid, 32'd0);
        check("abort_in_ready", bus.in_ready, 32'd1);
        check("abort_busy", bus.busy, 32'd0);
        check("abort_out_vec", bus.out_vec, 32'd0);
        send(12'h0A5); finish_vec(0, 1'b0, 0);

        prog(2);
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(0, 3)) begin
                cfg(1'($urandom), $urandom_range(0, NN - 1), $urandom_range(0, DEPTH - 1), 1'($urandom),
                    1'($urandom), $urandom_range(0, NN - 1), $urandom_range(0, FAN_IN - 1),
                    $urandom_range(0, 15));
            end
            v = IN_W'($urandom);
            send(v);
            finish_vec($urandom_range(0, 3), 1'($urandom), $urandom_range(0, DEPTH - 1));
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
